// File: rtl/router_rx.sv
// router_rx: serial receiver for the router link.
// Reassembles a start/data/stop frame sampled on a 16x baud grid into a
// single-word holding register read over a WISHBONE slave port, and drives
// rts so the upstream transmitter pauses while the holding word is unread.
module router_rx #(
  parameter int DW  = 129,
  parameter int OVS = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cyc_i,
  input  logic          stb_i,
  output logic          ack_o,
  input  logic          we_i,
  output logic [DW-1:0] dat_o,
  input  logic          cs_i,
  input  logic          baud16x_ce,
  input  logic          rxd,
  output logic          rts,
  output logic          full,
  output logic          overrun,
  output logic          frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [3:0] LP_MID  = 4'(OVS / 2 - 1);
  localparam logic [3:0] LP_LAST = 4'(OVS - 1);
  localparam logic [7:0] LP_LAST_BIT = 8'(DW - 1);

  state_t          r_state;
  state_t          w_stateNext;
  logic [1:0]      r_sync;
  logic [3:0]      r_phase;
  logic [7:0]      r_bitCnt;
  logic [DW-1:0]   r_shift;
  logic [DW-1:0]   r_dat;
  logic            r_full;
  logic            r_overrun;
  logic            r_frameErr;

  logic            w_rx;
  logic            w_readAck;
  logic            w_writeAck;
  logic            w_phaseMid;
  logic            w_phaseLast;
  logic            w_lastBit;
  logic            w_shiftEn;
  logic            w_load;
  logic            w_setOvr;
  logic            w_setFe;
  logic            w_phaseClr;
  logic            w_bitClr;

  assign w_rx        = r_sync[1];
  assign ack_o       = cyc_i & stb_i & cs_i;
  assign w_readAck   = ack_o & ~we_i;
  assign w_writeAck  = ack_o & we_i;
  assign w_phaseMid  = (r_phase == LP_MID);
  assign w_phaseLast = (r_phase == LP_LAST);
  assign w_lastBit   = (r_bitCnt == LP_LAST_BIT);

  assign dat_o     = r_dat;
  assign full      = r_full;
  assign overrun   = r_overrun;
  assign frame_err = r_frameErr;
  assign rts       = ~r_full;

  // Two-flop synchronizer on the line; idles high so reset looks like an idle line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_sync <= 2'b11;
    else         r_sync <= {r_sync[0], rxd};
  end

  // Receiver state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_stateNext;
  end

  // Next-state logic; the frame machine only moves on baud ticks.
  always_comb begin
    w_stateNext = r_state;
    if (baud16x_ce) begin
      case (r_state)
        S_IDLE:  if (!w_rx) w_stateNext = S_START;
        S_START: if (w_phaseMid) w_stateNext = w_rx ? S_IDLE : S_DATA;
        S_DATA:  if (w_phaseLast && w_lastBit) w_stateNext = S_STOP;
        S_STOP:  if (w_phaseLast) w_stateNext = w_rx ? S_IDLE : S_BREAK;
        S_BREAK: if (w_rx) w_stateNext = S_IDLE;
        default: w_stateNext = S_IDLE;
      endcase
    end
  end

  // Per-state control strobes for the datapath and the holding register.
  always_comb begin
    w_shiftEn  = 1'b0;
    w_load     = 1'b0;
    w_setOvr   = 1'b0;
    w_setFe    = 1'b0;
    w_phaseClr = 1'b0;
    w_bitClr   = 1'b0;
    if (baud16x_ce) begin
      case (r_state)
        S_IDLE:  w_phaseClr = 1'b1;
        S_START: begin
          w_bitClr   = 1'b1;
          w_phaseClr = w_phaseMid;
        end
        S_DATA:  w_shiftEn = w_phaseLast;
        S_STOP: begin
          if (w_phaseLast) begin
            w_load   = w_rx & (~r_full | w_readAck);
            w_setOvr = w_rx & r_full & ~w_readAck;
            w_setFe  = ~w_rx;
          end
        end
        S_BREAK: w_phaseClr = 1'b1;
        default: w_phaseClr = 1'b1;
      endcase
    end
  end

  // Bit-phase counter, bit counter and LSB-first shift register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_phase  <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
    end else if (baud16x_ce) begin
      r_phase <= w_phaseClr ? 4'd0 : r_phase + 4'd1;
      if (w_bitClr) begin
        r_bitCnt <= '0;
      end else if (w_shiftEn) begin
        r_bitCnt <= r_bitCnt + 8'd1;
        r_shift  <= {w_rx, r_shift[DW-1:1]};
      end
    end
  end

  // Holding register and sticky flags; a load or new error beats a same-edge clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dat      <= '0;
      r_full     <= 1'b0;
      r_overrun  <= 1'b0;
      r_frameErr <= 1'b0;
    end else begin
      if (w_load)         r_dat <= r_shift;
      if (w_load)         r_full <= 1'b1;
      else if (w_readAck) r_full <= 1'b0;
      if (w_setOvr)        r_overrun <= 1'b1;
      else if (w_writeAck) r_overrun <= 1'b0;
      if (w_setFe)         r_frameErr <= 1'b1;
      else if (w_writeAck) r_frameErr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_router_rx.sv
// Testbench for router_rx: directed frames on a half-rate baud tick, with a
// scoreboard queue of expected words checked by an independent monitor.
module tb_router_rx;

  localparam int DW = 129;
  localparam int FRAME_TICKS = 131 * 16;
  // Start is seen on tick 2 (synchronizer lag); stop sampled 2088 ticks later.
  localparam int STOP_TICK = 2 + 2088;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          cyc_i, stb_i, we_i, cs_i;
  logic          baud16x_ce;
  logic          rxd;
  logic          ack_o;
  logic [DW-1:0] dat_o;
  logic          rts, full, overrun, frame_err;

  int            nChecks = 0;
  int            nFails  = 0;
  logic [DW-1:0] expQ[$];

  localparam logic [DW-1:0] P1 = 129'h1_0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [DW-1:0] P5A = 129'h0_DEADBEEF01234567_89ABCDEF55AA33CC;
  localparam logic [DW-1:0] P5B = 129'h1_CAFEF00D76543210_0F1E2D3C4B5A6978;
  localparam logic [DW-1:0] P6 = 129'h1_00000000_00000000_00000000_00000001;

  router_rx dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cyc_i(cyc_i), .stb_i(stb_i),
    .ack_o(ack_o), .we_i(we_i), .dat_o(dat_o), .cs_i(cs_i),
    .baud16x_ce(baud16x_ce), .rxd(rxd), .rts(rts), .full(full),
    .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One baud tick: ce high for one clock, low for the next.
  task automatic baudTick();
    baud16x_ce = 1'b1;
    @(posedge clk_i); #1;
    baud16x_ce = 1'b0;
    cyc_i = 1'b0; stb_i = 1'b0; cs_i = 1'b0; we_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic holdLine(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      rxd = level;
      baudTick();
    end
  endtask

  // Send ticks 1..lastTick of a frame; optionally a read ack on tick ackTick.
  task automatic applyStimulus(input logic [DW-1:0] payload, input logic stopBit,
                               input int ackTick, input int lastTick);
    logic [DW+1:0] frame;
    frame = {stopBit, payload, 1'b0};
    for (int t = 1; t <= lastTick; t++) begin
      rxd = frame[(t - 1) / 16];
      if (t == ackTick) begin
        cyc_i = 1'b1; stb_i = 1'b1; cs_i = 1'b1; we_i = 1'b0;
      end
      baudTick();
    end
  endtask

  task automatic busAccess(input logic write, input string name);
    cyc_i = 1'b1; stb_i = 1'b1; cs_i = 1'b1; we_i = write;
    #1;
    checkOutput({name, " ack_o"}, ack_o, 1);
    @(posedge clk_i); #1;
    cyc_i = 1'b0; stb_i = 1'b0; cs_i = 1'b0; we_i = 1'b0;
  endtask

  // Monitor: any new word in the holding register must match the queue head.
  logic          prevFull = 1'b0;
  logic [DW-1:0] prevDat = '0;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      prevFull = 1'b0;
      prevDat  = '0;
    end else begin
      if ((full && !prevFull) || (dat_o !== prevDat)) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL monitor unexpected word: got %h expected none", dat_o);
        end else begin
          checkOutput("monitor dat_o", dat_o, expQ.pop_front());
        end
      end
      prevFull = full;
      prevDat  = dat_o;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_ni = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; cs_i = 1'b0;
    baud16x_ce = 1'b0; rxd = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset dat_o", dat_o, 0);
    checkOutput("reset full", full, 0);
    checkOutput("reset rts", rts, 1);
    checkOutput("reset overrun", overrun, 0);
    checkOutput("reset frame_err", frame_err, 0);
    rst_ni = 1'b1;
    holdLine(1'b1, 4);

    $display("[TB] test 1: single frame and read");
    expQ.push_back(P1);
    applyStimulus(P1, 1'b1, 0, FRAME_TICKS);
    checkOutput("t1 full", full, 1);
    checkOutput("t1 rts", rts, 0);
    checkOutput("t1 dat_o", dat_o, P1);
    cyc_i = 1'b1; stb_i = 1'b1; cs_i = 1'b0;
    #1;
    checkOutput("t1 ack_o no cs", ack_o, 0);
    busAccess(1'b0, "t1 read");
    checkOutput("t1 full after read", full, 0);
    checkOutput("t1 rts after read", rts, 1);
    checkOutput("t1 dat_o kept", dat_o, P1);

    $display("[TB] test 2: false start glitch");
    holdLine(1'b0, 4);
    holdLine(1'b1, 30);
    checkOutput("t2 full", full, 0);
    checkOutput("t2 overrun", overrun, 0);
    checkOutput("t2 frame_err", frame_err, 0);

    $display("[TB] test 3: overrun");
    expQ.push_back('0);
    applyStimulus('0, 1'b1, 0, FRAME_TICKS);
    holdLine(1'b1, 2);
    applyStimulus({DW{1'b1}}, 1'b1, 0, FRAME_TICKS);
    holdLine(1'b1, 2);
    checkOutput("t3 overrun", overrun, 1);
    checkOutput("t3 dat_o", dat_o, 0);
    checkOutput("t3 full", full, 1);
    busAccess(1'b1, "t3 write");
    checkOutput("t3 overrun cleared", overrun, 0);
    busAccess(1'b0, "t3 read");
    checkOutput("t3 full cleared", full, 0);

    $display("[TB] test 4: framing error and break");
    applyStimulus(129'h3, 1'b0, 0, FRAME_TICKS);
    holdLine(1'b0, 100);
    checkOutput("t4 frame_err", frame_err, 1);
    checkOutput("t4 full", full, 0);
    holdLine(1'b1, 10);
    expQ.push_back(129'h5A);
    applyStimulus(129'h5A, 1'b1, 0, FRAME_TICKS);
    checkOutput("t4 full after break", full, 1);
    checkOutput("t4 dat_o", dat_o, 129'h5A);
    checkOutput("t4 frame_err sticky", frame_err, 1);
    busAccess(1'b1, "t4 write");
    checkOutput("t4 frame_err cleared", frame_err, 0);
    busAccess(1'b0, "t4 read");

    $display("[TB] test 5: read ack on stop sample");
    expQ.push_back(P5A);
    applyStimulus(P5A, 1'b1, 0, FRAME_TICKS);
    holdLine(1'b1, 4);
    expQ.push_back(P5B);
    applyStimulus(P5B, 1'b1, STOP_TICK, FRAME_TICKS);
    checkOutput("t5 full", full, 1);
    checkOutput("t5 dat_o", dat_o, P5B);
    checkOutput("t5 overrun", overrun, 0);

    $display("[TB] test 6: reset mid-frame");
    holdLine(1'b1, 4);
    applyStimulus(P5A, 1'b1, 0, 975);
    rxd = 1'b1;
    rst_ni = 1'b0;
    #1;
    checkOutput("t6 dat_o", dat_o, 0);
    checkOutput("t6 full", full, 0);
    checkOutput("t6 rts", rts, 1);
    checkOutput("t6 overrun", overrun, 0);
    checkOutput("t6 frame_err", frame_err, 0);
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    holdLine(1'b1, 4);
    expQ.push_back(P6);
    applyStimulus(P6, 1'b1, 0, FRAME_TICKS);
    checkOutput("t6 full after frame", full, 1);
    checkOutput("t6 dat_o after frame", dat_o, P6);

    holdLine(1'b1, 4);
    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
